// File: rtl/servo_pkg.sv
// Shared constants and FSM state type for the servo command frame writer.
package servo_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hFF;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHAN   = 3'd1,
      POS    = 3'd2,
      SETUP  = 3'd3,
      STROBE = 3'd4
   } state_t;

endpackage

// File: rtl/servo_cmd_writer.sv
// Parses FF/channel/position byte frames and drives a one-cycle active-low latch strobe.
// Optional inter-byte timeout is compiled in with SERVO_CMD_TIMEOUT_EN.
module servo_cmd_writer
   import servo_pkg::*;
#(
   parameter int CHANNELS       = 4,
   parameter int NBITS          = 2,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   output logic             rx_ready,
   output logic [NBITS-1:0] address,
   output logic [7:0]       data,
   output logic             latch,
   output logic             err,
   output state_t           dbg_state
);

   // Upstream handshake: a byte moves only on a cycle where rx_valid and rx_ready are both high.

   if (CHANNELS > (2 ** NBITS) || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("servo_cmd_writer: CHANNELS must fit in NBITS and TIMEOUT_CYCLES must be >= 1");
   end

   state_t           state_q;
   logic [NBITS-1:0] addr_q;
   logic [7:0]       data_q;
   logic             latch_q;
   logic             err_q;
   logic             ready_q;
   logic             accept;

   assign accept = rx_valid && ready_q;

`ifdef SERVO_CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmr_q;
   logic          timeout;

   // Only meaningful while waiting for a channel or position byte.
   assign timeout = (state_q == CHAN || state_q == POS) && !accept && (tmr_q == TMR_LAST);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         latch_q <= 1'b1;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
`ifdef SERVO_CMD_TIMEOUT_EN
         tmr_q   <= '0;
`endif
      end else begin
         err_q   <= 1'b0;
         latch_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (accept && rx_data == SYNC_BYTE) state_q <= CHAN;
            end
            CHAN: begin
               if (accept) begin
                  if (rx_data == SYNC_BYTE) begin
                     state_q <= CHAN;
                  end else if (int'(rx_data) < CHANNELS) begin
                     addr_q  <= rx_data[NBITS-1:0];
                     state_q <= POS;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= IDLE;
                  end
               end
`ifdef SERVO_CMD_TIMEOUT_EN
               else if (timeout) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end
`endif
            end
            POS: begin
               if (accept) begin
                  data_q  <= rx_data;
                  ready_q <= 1'b0;
                  state_q <= SETUP;
               end
`ifdef SERVO_CMD_TIMEOUT_EN
               else if (timeout) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end
`endif
            end
            SETUP: begin
               latch_q <= 1'b0;
               state_q <= STROBE;
            end
            STROBE: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
`ifdef SERVO_CMD_TIMEOUT_EN
         if (accept || timeout || !(state_q == CHAN || state_q == POS)) tmr_q <= '0;
         else tmr_q <= tmr_q + 1'b1;
`endif
      end
   end

   assign rx_ready  = ready_q;
   assign address   = addr_q;
   assign data      = data_q;
   assign latch     = latch_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: doc/servo_cmd_writer.md
SERVO_CMD_WRITER -- requirements
Module: servo_cmd_writer

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, the number of servo channels addressable.
REQ-002 The block SHALL have parameter NBITS, default 2, the address width, with CHANNELS <= 2**NBITS.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, the maximum inter-byte gap in clk cycles.
REQ-004 clk  input  1  single system clock; all logic on posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 rx_valid  input  1  byte-stream valid from upstream serial receiver.
REQ-007 rx_data  input  8  byte-stream data.
REQ-008 rx_ready  output  1  block accepts a byte on a cycle where rx_valid and rx_ready are both high.
REQ-009 address  output  NBITS  channel select to the channel address decoder.
REQ-010 data  output  8  position value to the channel registers.
REQ-011 latch  output  1  active-low load strobe; idle high.
REQ-012 err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-013 Frame format SHALL be: sync byte 8'hFF, channel byte, position byte.
REQ-014 FSM states SHALL be IDLE, CHAN, POS, SETUP, STROBE.
REQ-015 IDLE: accepted byte 8'hFF -> CHAN; any other accepted byte is discarded and the FSM stays in IDLE.
REQ-016 CHAN: accepted 8'hFF stays in CHAN (resync); value < CHANNELS is captured into address, then POS; value >= CHANNELS -> err pulses the next cycle, then IDLE.
REQ-017 POS: any accepted byte, including 8'hFF, is captured into data, then SETUP.
REQ-018 SETUP: address and data are stable, latch is high, then STROBE unconditionally.
REQ-019 STROBE: latch is low for exactly one cycle, address and data are held, then IDLE.
REQ-020 rx_ready SHALL be high in IDLE, CHAN and POS, and low in SETUP and STROBE.
REQ-021 Latency from acceptance of the position byte to the latch-low cycle SHALL be exactly 2 cycles.
REQ-022 address and data SHALL hold their last values in IDLE and change only on capture.
REQ-023 err and a latch-low cycle SHALL never occur in the same cycle.

Reset
REQ-024 On rst_n low, the state SHALL go to IDLE and the outputs SHALL be: address=0, data=0, latch=1, err=0, rx_ready=1, timeout counter=0, asynchronously.
REQ-025 Reset asserted mid-frame, including during STROBE, SHALL abort the frame with no further latch pulse.

Configuration
REQ-026 Macro SERVO_CMD_TIMEOUT_EN SHALL be the only configuration macro.
REQ-027 With SERVO_CMD_TIMEOUT_EN defined:
- A counter clears on each accepted byte and increments in CHAN and POS.
- When the counter reaches TIMEOUT_CYCLES with no accepted byte, the FSM returns to IDLE and err pulses for one cycle.
- A byte accepted in the same cycle as the timeout takes precedence.
REQ-028 Without SERVO_CMD_TIMEOUT_EN, no counter SHALL be synthesized and CHAN/POS SHALL wait indefinitely.

Structure
REQ-029 Shared package servo_pkg SHALL hold the SYNC_BYTE constant (8'hFF) and the FSM state typedef.
REQ-030 The block SHALL be a single module with no sub-modules; the timeout counter is inline, under the macro.

Verification
REQ-031 Bytes FF,02,80 with rx_valid held high -> address=2, data=8'h80, latch low exactly 2 cycles after the 80 is accepted, err=0.
REQ-032 Bytes FF,05,10 with CHANNELS=4 -> err pulses 1 cycle, latch stays high, next frame FF,01,20 latches address=1, data=8'h20.
REQ-033 Bytes FF,FF,03,FF -> resync in CHAN, address=3, data=8'hFF latched.
REQ-034 rx_valid held high during SETUP/STROBE -> rx_ready=0 and no byte consumed; the following frame is parsed correctly.
REQ-035 With the macro defined and TIMEOUT_CYCLES=8: FF,01, then 8 idle cycles -> err pulse, FSM back in IDLE, no latch pulse; without the macro -> FSM stays in POS.
REQ-036 rst_n asserted during the STROBE cycle -> latch=1 immediately, all outputs at reset values, no further latch pulse.
